src_sel_ctrl: RTL

Source-selection sequencer for the 16-bit pattern-source mux (counter, PRBS, const, const_bar) on the FMCA test path.
- Turns raw push-button presses and a PLL lock indication into a clean `sel` code for the mux.
- Optionally auto-cycles through the sources on a dwell timer.
- Asserts a blanking window after every source change so the receiving checker can resynchronise.
- Runs entirely in the `clk1280` domain, between the PLL/push buttons and the source mux.

---
 rtl/src_sel_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/src_sel_ctrl.sv
// Source-selection sequencer for the pattern-source mux: debounces the push buttons,
// follows PLL lock, optionally auto-cycles sources and blanks the output after each change.
module src_sel_ctrl #(
   parameter int DEB_CYCLES   = 1280000,
   parameter int DWELL_CYCLES = 128000000,
   parameter int GUARD_WORDS  = 8,
   parameter int NUM_SRC      = 4
) (
   input  logic       clk1280,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic [1:0] pb,
   output logic [1:0] sel,
   output logic [1:0] indic,
   output logic       blank,
   output logic       src_switch,
   output logic       auto_mode
);

   localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
   localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
   localparam int GUARD_W = $clog2(GUARD_WORDS + 1);

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_GUARD     = 2'd1,
      S_RUN       = 2'd2
   } state_t;

   logic [1:0] r_pb_meta;
   logic [1:0] r_pb_sync;
   logic       r_lock_meta;
   logic       r_lock_sync;
   logic [1:0] w_press;

   always_ff @(posedge clk1280 or posedge rst) begin
      if (rst) begin
         r_pb_meta   <= 2'b11;
         r_pb_sync   <= 2'b11;
         r_lock_meta <= 1'b0;
         r_lock_sync <= 1'b0;
      end else begin
         r_pb_meta   <= pb;
         r_pb_sync   <= r_pb_meta;
         r_lock_meta <= pll_locked;
         r_lock_sync <= r_lock_meta;
      end
   end

   // Per-button debounce; a press event fires on the edge the debounced level falls.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_deb
         logic [DEB_W-1:0] r_cnt;
         logic             r_lvl;
         logic             r_evt;

         always_ff @(posedge clk1280 or posedge rst) begin
            if (rst) begin
               r_cnt <= '0;
               r_lvl <= 1'b1;
               r_evt <= 1'b0;
            end else begin
               r_evt <= 1'b0;
               if (r_pb_sync[gi] == r_lvl) begin
                  r_cnt <= '0;
               end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                  r_cnt <= '0;
                  r_lvl <= r_pb_sync[gi];
                  r_evt <= ~r_pb_sync[gi];
               end else begin
                  r_cnt <= r_cnt + DEB_W'(1);
               end
            end
         end

         assign w_press[gi] = r_evt;
      end
   endgenerate

   state_t             r_state;
   state_t             w_state_next;
   logic [GUARD_W-1:0] r_guard;
   logic [GUARD_W-1:0] w_guard_next;
   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] w_dwell_next;
   logic [1:0]         r_sel;
   logic [1:0]         w_sel_next;
   logic [1:0]         r_indic;
   logic               r_blank;
   logic               w_blank_next;
   logic               r_switch;
   logic               w_switch_next;
   logic               r_auto;
   logic               w_auto_next;
   logic [1:0]         w_sel_inc;
   logic               w_dwell_done;

   assign w_sel_inc    = (r_sel == 2'(NUM_SRC - 1)) ? 2'd0 : r_sel + 2'd1;
   assign w_dwell_done = r_auto && (r_dwell == DWELL_W'(DWELL_CYCLES - 1));

   always_ff @(posedge clk1280 or posedge rst) begin
      if (rst) begin
         r_state  <= S_WAIT_LOCK;
         r_guard  <= '0;
         r_dwell  <= '0;
         r_sel    <= 2'd0;
         r_indic  <= 2'd0;
         r_blank  <= 1'b1;
         r_switch <= 1'b0;
         r_auto   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_guard  <= w_guard_next;
         r_dwell  <= w_dwell_next;
         r_sel    <= w_sel_next;
         r_indic  <= w_sel_next;
         r_blank  <= w_blank_next;
         r_switch <= w_switch_next;
         r_auto   <= w_auto_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_guard_next  = r_guard;
      w_dwell_next  = r_dwell;
      w_sel_next    = r_sel;
      w_auto_next   = r_auto;
      w_blank_next  = r_blank;
      w_switch_next = 1'b0;

      // Lock loss overrides everything; sel and auto mode survive it.
      if (!r_lock_sync) begin
         w_state_next = S_WAIT_LOCK;
         w_blank_next = 1'b1;
         w_dwell_next = '0;
      end else begin
         case (r_state)
            S_WAIT_LOCK: begin
               w_state_next = S_GUARD;
               w_guard_next = GUARD_W'(GUARD_WORDS - 1);
               w_blank_next = 1'b1;
               w_dwell_next = '0;
            end
            S_GUARD: begin
               w_blank_next = 1'b1;
               if (w_press[1]) begin
                  w_auto_next = ~r_auto;
               end
               if (r_guard == '0) begin
                  w_state_next = S_RUN;
                  w_blank_next = 1'b0;
               end else begin
                  w_guard_next = r_guard - GUARD_W'(1);
               end
            end
            S_RUN: begin
               w_blank_next = 1'b0;
               if (r_auto) begin
                  w_dwell_next = r_dwell + DWELL_W'(1);
               end
               if (w_press[0] || w_dwell_done) begin
                  w_sel_next    = w_sel_inc;
                  w_switch_next = 1'b1;
                  w_dwell_next  = '0;
                  w_state_next  = S_GUARD;
                  w_guard_next  = GUARD_W'(GUARD_WORDS - 1);
                  w_blank_next  = 1'b1;
               end
               if (w_press[1]) begin
                  w_auto_next  = ~r_auto;
                  w_dwell_next = '0;
               end
            end
            default: begin
               w_state_next = S_WAIT_LOCK;
               w_blank_next = 1'b1;
            end
         endcase
      end
   end

   assign sel        = r_sel;
   assign indic      = r_indic;
   assign blank      = r_blank;
   assign src_switch = r_switch;
   assign auto_mode  = r_auto;

endmodule
